// File: rtl/lb_pkg.sv
// Shared types and constants for the AXI-Lite to local-bus master.
package lb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_RESP = 2'd1,
    RD_WAIT = 2'd2,
    RD_RESP = 2'd3
  } lb_state_t;

  localparam logic [1:0]  OKAY      = 2'b00;
  localparam logic [1:0]  SLVERR    = 2'b10;
  localparam logic [31:0] LB_RD_ERR = 32'hdeadbeef;

  function automatic logic [1:0] wr_resp(input logic strb_full);
    return strb_full ? OKAY : SLVERR;
  endfunction

endpackage

// File: rtl/lb_delay_line.sv
// Delay lines for the local-bus read strobe, last flag and read address.
module lb_delay_line #(
  parameter int ADDR_WIDTH = 24,
  parameter int DEPTH      = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rden,
  input  logic                        rdenlast,
  input  logic [ADDR_WIDTH-1:0]       raddr,
  output logic [DEPTH-1:0]            rden_dly,
  output logic [DEPTH-1:0]            rdenlast_dly,
  output logic [DEPTH*ADDR_WIDTH-1:0] raddr_dly
);

  logic [DEPTH-1:1]            rden_sr;
  logic [DEPTH-1:1]            last_sr;
  logic [DEPTH*ADDR_WIDTH-1:0] addr_sr;

  // Strobe slots start at zero delay; address slot j lags by j+1 cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rden_sr <= '0;
      last_sr <= '0;
      addr_sr <= '0;
    end else begin
      rden_sr <= {rden_sr[DEPTH-2:1], rden};
      last_sr <= {last_sr[DEPTH-2:1], rdenlast};
      addr_sr <= {addr_sr[(DEPTH-1)*ADDR_WIDTH-1:0], raddr};
    end
  end

  assign rden_dly     = {rden_sr, rden};
  assign rdenlast_dly = {last_sr, rdenlast};
  assign raddr_dly    = addr_sr;

endmodule

// File: rtl/axil_lb_master.sv
// AXI-Lite slave that turns single transactions into local-bus strobes,
// one transaction outstanding, with read timeout and R/W round-robin.
module axil_lb_master
  import lb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 24,
  parameter int TIMEOUT    = 31
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_WIDTH+1:0]    s_axi_awaddr,
  input  logic                     s_axi_awvalid,
  output logic                     s_axi_awready,
  input  logic [DATA_WIDTH-1:0]    s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]  s_axi_wstrb,
  input  logic                     s_axi_wvalid,
  output logic                     s_axi_wready,
  output logic [1:0]               s_axi_bresp,
  output logic                     s_axi_bvalid,
  input  logic                     s_axi_bready,
  input  logic [ADDR_WIDTH+1:0]    s_axi_araddr,
  input  logic                     s_axi_arvalid,
  output logic                     s_axi_arready,
  output logic [DATA_WIDTH-1:0]    s_axi_rdata,
  output logic [1:0]               s_axi_rresp,
  output logic                     s_axi_rvalid,
  input  logic                     s_axi_rready,
  output logic                     lb_wren,
  output logic [ADDR_WIDTH-1:0]    lb_waddr,
  output logic [DATA_WIDTH-1:0]    lb_wdata,
  output logic                     lb_rden,
  output logic [ADDR_WIDTH-1:0]    lb_raddr,
  output logic [15:0]              lb_rden16,
  output logic [15:0]              lb_rdenlast16,
  output logic [16*ADDR_WIDTH-1:0] lb_raddr16,
  input  logic [DATA_WIDTH-1:0]    lb_rdata,
  input  logic                     lb_rvalid,
  input  logic                     lb_rvalidlast
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  lb_state_t               state, state_next;
  logic                    aw_latched, w_latched, last_was_read;
  logic [ADDR_WIDTH-1:0]   awaddr_r;
  logic [DATA_WIDTH-1:0]   wdata_r;
  logic [DATA_WIDTH/8-1:0] wstrb_r;
  logic [CNT_W-1:0]        cnt;
  logic aw_hs, w_hs, ar_hs, do_write, rd_start, rd_capture, rd_timeout;
  logic unused_bits;

  assign unused_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0], lb_rvalidlast};

  // A read yields to a same-cycle complete write only when the read went last.
  assign s_axi_awready = (state == IDLE) && !aw_latched;
  assign s_axi_wready  = (state == IDLE) && !w_latched;
  assign s_axi_arready = (state == IDLE) && !aw_latched && !w_latched &&
                         !(s_axi_awvalid && s_axi_wvalid && last_was_read);

  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs  = s_axi_wvalid && s_axi_wready;
  assign ar_hs = s_axi_arvalid && s_axi_arready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    do_write   = 1'b0;
    rd_start   = 1'b0;
    rd_capture = 1'b0;
    rd_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (aw_latched && w_latched) begin
          do_write   = 1'b1;
          state_next = WR_RESP;
        end else if (ar_hs) begin
          rd_start   = 1'b1;
          state_next = RD_WAIT;
        end else begin
          state_next = IDLE;
        end
      end
      WR_RESP: state_next = s_axi_bready ? IDLE : WR_RESP;
      RD_WAIT: begin
        if (lb_rvalid) begin
          rd_capture = 1'b1;
          state_next = RD_RESP;
        end else if (cnt == CNT_W'(TIMEOUT)) begin
          rd_timeout = 1'b1;
          state_next = RD_RESP;
        end else begin
          state_next = RD_WAIT;
        end
      end
      RD_RESP: state_next = s_axi_rready ? IDLE : RD_RESP;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_latched    <= 1'b0;
      w_latched     <= 1'b0;
      awaddr_r      <= '0;
      wdata_r       <= '0;
      wstrb_r       <= '0;
      last_was_read <= 1'b0;
      cnt           <= '0;
      lb_wren       <= 1'b0;
      lb_waddr      <= '0;
      lb_wdata      <= '0;
      lb_rden       <= 1'b0;
      lb_raddr      <= '0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= 2'b00;
      s_axi_rvalid  <= 1'b0;
      s_axi_rresp   <= 2'b00;
      s_axi_rdata   <= '0;
    end else begin
      lb_wren <= 1'b0;
      lb_rden <= 1'b0;
      if (aw_hs) begin
        aw_latched <= 1'b1;
        awaddr_r   <= s_axi_awaddr[ADDR_WIDTH+1:2];
      end
      if (w_hs) begin
        w_latched <= 1'b1;
        wdata_r   <= s_axi_wdata;
        wstrb_r   <= s_axi_wstrb;
      end
      // Partial strobes are refused outright: no local-bus write at all.
      if (do_write) begin
        if (&wstrb_r) begin
          lb_wren  <= 1'b1;
          lb_waddr <= awaddr_r;
          lb_wdata <= wdata_r;
        end
        s_axi_bresp   <= wr_resp(&wstrb_r);
        s_axi_bvalid  <= 1'b1;
        last_was_read <= 1'b0;
      end
      if (state == WR_RESP && s_axi_bready) begin
        s_axi_bvalid <= 1'b0;
        aw_latched   <= 1'b0;
        w_latched    <= 1'b0;
      end
      if (rd_start) begin
        lb_rden       <= 1'b1;
        lb_raddr      <= s_axi_araddr[ADDR_WIDTH+1:2];
        cnt           <= '0;
        last_was_read <= 1'b1;
      end
      if (state == RD_WAIT && !rd_capture && !rd_timeout) cnt <= cnt + CNT_W'(1);
      if (rd_capture) begin
        s_axi_rdata  <= lb_rdata;
        s_axi_rresp  <= OKAY;
        s_axi_rvalid <= 1'b1;
      end
      if (rd_timeout) begin
        s_axi_rdata  <= DATA_WIDTH'(LB_RD_ERR);
        s_axi_rresp  <= SLVERR;
        s_axi_rvalid <= 1'b1;
      end
      if (state == RD_RESP && s_axi_rready) s_axi_rvalid <= 1'b0;
    end
  end

  lb_delay_line #(.ADDR_WIDTH(ADDR_WIDTH), .DEPTH(16)) u_delay (
    .clk          (clk),
    .rst          (rst),
    .rden         (lb_rden),
    .rdenlast     (lb_rden),
    .raddr        (lb_raddr),
    .rden_dly     (lb_rden16),
    .rdenlast_dly (lb_rdenlast16),
    .raddr_dly    (lb_raddr16)
  );

endmodule

// File: tb/tb_axil_lb_master.sv
// Self-checking bench for axil_lb_master: vector table, directed corners,
// and randomized traffic against a behavioural model with a local-bus responder.
module tb_axil_lb_master;

  localparam int DW = 32, AW = 24, TO = 31, READDELAY = 4;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic [AW+1:0] s_axi_awaddr = '0, s_axi_araddr = '0;
  logic s_axi_awvalid = 1'b0, s_axi_wvalid = 1'b0, s_axi_bready = 1'b0;
  logic s_axi_arvalid = 1'b0, s_axi_rready = 1'b0;
  logic [DW-1:0] s_axi_wdata = '0;
  logic [3:0] s_axi_wstrb = '0;
  logic s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid;
  logic [1:0] s_axi_bresp, s_axi_rresp;
  logic [DW-1:0] s_axi_rdata, lb_wdata, lb_rdata;
  logic lb_wren, lb_rden, lb_rvalid;
  logic [AW-1:0] lb_waddr, lb_raddr;
  logic [15:0] lb_rden16, lb_rdenlast16;
  logic [16*AW-1:0] lb_raddr16;

  logic resp_mode = 1'b0, late_pulse = 1'b0;
  logic [31:0] late_data = 32'h0;
  int n_pass = 0, n_total = 0, wren_cnt = 0, rden_cnt = 0;
  string order_str = "";

  function automatic logic [31:0] mdata(input logic [23:0] a);
    return {a[7:0], a} ^ 32'hA5C3_0F96;
  endfunction

  // Responder: answers READDELAY cycles after sampling the strobe, aligned with lb_rden16[5].
  assign lb_rvalid = (resp_mode && lb_rden16[READDELAY+1]) || late_pulse;
  assign lb_rdata  = resp_mode ? mdata(lb_raddr16[READDELAY*AW +: AW]) : late_data;

  axil_lb_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .lb_wren(lb_wren), .lb_waddr(lb_waddr), .lb_wdata(lb_wdata),
    .lb_rden(lb_rden), .lb_raddr(lb_raddr), .lb_rden16(lb_rden16),
    .lb_rdenlast16(lb_rdenlast16), .lb_raddr16(lb_raddr16),
    .lb_rdata(lb_rdata), .lb_rvalid(lb_rvalid), .lb_rvalidlast(lb_rvalid)
  );

  // Local-bus strobe monitor: counts pulses and records their order.
  always @(negedge clk) begin
    if (lb_wren) begin wren_cnt++; order_str = {order_str, "W"}; end
    if (lb_rden) begin rden_cnt++; order_str = {order_str, "R"}; end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic do_write(input logic [25:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int lead, input logic exp_wren, input logic [23:0] exp_waddr,
                          input logic [1:0] exp_bresp);
    int w0;
    int k;
    w0 = wren_cnt;
    s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
    if (lead == 0) begin
      s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
      @(negedge clk); s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    end else if (lead > 0) begin
      s_axi_wvalid = 1'b1; @(negedge clk); s_axi_wvalid = 1'b0;
      repeat (lead - 1) @(negedge clk);
      s_axi_awvalid = 1'b1; @(negedge clk); s_axi_awvalid = 1'b0;
    end else begin
      s_axi_awvalid = 1'b1; @(negedge clk); s_axi_awvalid = 1'b0;
      repeat (-lead - 1) @(negedge clk);
      s_axi_wvalid = 1'b1; @(negedge clk); s_axi_wvalid = 1'b0;
    end
    k = 0;
    while (!s_axi_bvalid && k < 20) begin @(negedge clk); k++; end
    check("bvalid_seen", s_axi_bvalid, 1'b1);
    check("bresp", s_axi_bresp, exp_bresp);
    s_axi_bready = 1'b1; @(negedge clk); s_axi_bready = 1'b0;
    check("bvalid_clear", s_axi_bvalid, 1'b0);
    check("wren_count", wren_cnt - w0, exp_wren ? 1 : 0);
    if (exp_wren) begin
      check("lb_waddr", lb_waddr, exp_waddr);
      check("lb_wdata", lb_wdata, d);
    end
  endtask

  task automatic do_read(input logic [25:0] a, input logic mode, input logic late);
    logic [31:0] exp_d;
    logic [1:0]  exp_r;
    int exp_lat, k;
    exp_d   = mode ? mdata(a[25:2]) : 32'hdeadbeef;
    exp_r   = mode ? 2'b00 : 2'b10;
    exp_lat = mode ? READDELAY + 2 : TO + 1;
    resp_mode = mode; s_axi_araddr = a; s_axi_arvalid = 1'b1;
    @(negedge clk); s_axi_arvalid = 1'b0;
    check("rden_pulse", lb_rden, 1'b1);
    check("lb_raddr", lb_raddr, a[25:2]);
    check("rdenlast0", lb_rdenlast16[0], 1'b1);
    k = 0;
    while (!s_axi_rvalid && k < 80) begin
      if (mode && k == 4) begin
        check("rden16_4", lb_rden16[4], 1'b1);
        check("raddr16_slot3", lb_raddr16[3*AW +: AW], a[25:2]);
      end
      if (mode && k == 5) check("rvalid_align", {lb_rden16[5], lb_rvalid}, 2'b11);
      @(negedge clk); k++;
    end
    check("rvalid_seen", s_axi_rvalid, 1'b1);
    check("rd_latency", k, exp_lat);
    check("rdata", s_axi_rdata, exp_d);
    check("rresp", s_axi_rresp, exp_r);
    if (late) begin
      late_data = 32'h0BAD_0BAD; late_pulse = 1'b1; @(negedge clk); late_pulse = 1'b0;
      check("late_in_rresp", s_axi_rdata, exp_d);
    end
    s_axi_rready = 1'b1; @(negedge clk); s_axi_rready = 1'b0;
    check("rvalid_clear", s_axi_rvalid, 1'b0);
    if (late) begin
      late_pulse = 1'b1; @(negedge clk); late_pulse = 1'b0; @(negedge clk);
      check("late_in_idle", s_axi_rvalid, 1'b0);
    end
  endtask

  typedef struct {
    logic [25:0] awaddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          lead;
    logic        exp_wren;
    logic [23:0] exp_waddr;
    logic [1:0]  exp_bresp;
  } wvec_t;

  wvec_t tbl[5];

  initial begin
    string exp_order;
    logic lr, a_hs, aw_hs, w_hs, stable, r0v;
    logic [25:0] ra;
    int r0;

    tbl[0] = '{26'h0040010, 32'h12345678, 4'hF, 0,  1'b1, 24'h010004, 2'b00};
    tbl[1] = '{26'h0040020, 32'hCAFEF00D, 4'h3, 3,  1'b0, 24'h000000, 2'b10};
    tbl[2] = '{26'h0000FFC, 32'hA5A5A5A5, 4'hF, -2, 1'b1, 24'h0003FF, 2'b00};
    tbl[3] = '{26'h3FFFFFC, 32'hFFFFFFFF, 4'h0, 1,  1'b0, 24'h000000, 2'b10};
    tbl[4] = '{26'h3FFFFFC, 32'h00000001, 4'hF, 2,  1'b1, 24'hFFFFFF, 2'b00};

    repeat (3) @(negedge clk);
    check("rst_ready", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);
    check("rst_valids", {s_axi_bvalid, s_axi_rvalid, lb_wren, lb_rden}, 4'b0000);
    check("rst_dly", {lb_rden16, lb_rdenlast16}, 32'h0);
    check("rst_data", {s_axi_rdata, lb_waddr, lb_raddr}, 80'h0);
    rst = 1'b0;
    @(negedge clk);

    // Round-robin: read and complete write arrive together, four times.
    exp_order = ""; lr = 1'b0; order_str = "";
    resp_mode = 1'b1; s_axi_bready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (!lr) begin exp_order = {exp_order, "RW"}; lr = 1'b0; end
      else begin exp_order = {exp_order, "WR"}; lr = 1'b1; end
      ra = 26'(32'h0010_0000 + i * 4);
      s_axi_araddr = ra; s_axi_awaddr = 26'(32'h0003_0000 + i * 4);
      s_axi_wdata = $urandom; s_axi_wstrb = 4'hF;
      s_axi_arvalid = 1'b1; s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
      for (int k = 0; k < 80 && (s_axi_arvalid || s_axi_awvalid || s_axi_wvalid); k++) begin
        #1;
        a_hs = s_axi_arvalid && s_axi_arready;
        aw_hs = s_axi_awvalid && s_axi_awready;
        w_hs = s_axi_wvalid && s_axi_wready;
        @(negedge clk);
        if (a_hs) s_axi_arvalid = 1'b0;
        if (aw_hs) s_axi_awvalid = 1'b0;
        if (w_hs) s_axi_wvalid = 1'b0;
      end
      check("rr_handshakes", {s_axi_arvalid, s_axi_awvalid, s_axi_wvalid}, 3'b000);
      for (int k = 0; k < 80 && !s_axi_rvalid; k++) @(negedge clk);
      check("rr_rvalid", s_axi_rvalid, 1'b1);
      stable = 1'b1;
      repeat (10) begin
        @(negedge clk);
        if (s_axi_rdata !== mdata(ra[25:2]) || !s_axi_rvalid) stable = 1'b0;
      end
      check("rr_rdata_hold", stable, 1'b1);
      s_axi_rready = 1'b1; @(negedge clk); s_axi_rready = 1'b0;
      for (int k = 0; k < 80 && (order_str.len() < 2 * (i + 1) || s_axi_bvalid); k++) @(negedge clk);
      repeat (2) @(negedge clk);
    end
    s_axi_bready = 1'b0;
    n_total++;
    if (order_str == exp_order) n_pass++;
    else $display("FAIL rr_order: got %s expected %s", order_str, exp_order);

    for (int i = 0; i < 5; i++)
      do_write(tbl[i].awaddr, tbl[i].wdata, tbl[i].wstrb, tbl[i].lead,
               tbl[i].exp_wren, tbl[i].exp_waddr, tbl[i].exp_bresp);

    do_read(26'h0200000, 1'b1, 1'b0);
    do_read(26'h0000040, 1'b0, 1'b1);

    // Reset while waiting on the local bus.
    resp_mode = 1'b0; s_axi_araddr = 26'h0001230; s_axi_arvalid = 1'b1;
    @(negedge clk); s_axi_arvalid = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_dly", lb_rden16[3], 1'b1);
    rst = 1'b1; #1;
    check("mid_rst_dly", {lb_rden16, lb_rdenlast16}, 32'h0);
    check("mid_rst_state", {s_axi_rvalid, s_axi_arready}, 2'b01);
    @(negedge clk); rst = 1'b0;
    r0 = rden_cnt;
    repeat (40) @(negedge clk);
    r0v = s_axi_rvalid;
    check("post_rst_quiet", {rden_cnt - r0, 31'(r0v)}, 64'h0);
    do_read(26'h0000ABC, 1'b1, 1'b0);

    for (int i = 0; i < 16; i++) begin
      logic [25:0] a;
      logic [3:0]  s;
      logic [31:0] d;
      int lead;
      a = 26'($urandom);
      if ($urandom_range(0, 2) == 0) do_read(a, 1'b1, 1'b0);
      else begin
        s = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
        d = $urandom;
        lead = int'($urandom_range(0, 6)) - 3;
        do_write(a, d, s, lead, s == 4'hF, a[25:2], (s == 4'hF) ? 2'b00 : 2'b10);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
